spi_s: RTL and testbench
========================

SPI_S -- requirements
Module: spi_s

Interface
REQ-001 SHALL have port: clk  input  1  system clock; sclk, cs_n and mosi are sampled on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: sclk  input  1  SPI clock from the master, asynchronous to clk.
REQ-004 SHALL have port: cs_n  input  1  SPI chip select from the master, active-low, asynchronous.
REQ-005 SHALL have port: mosi  input  1  serial data from the master, MSB first.
REQ-006 SHALL have port: miso  output  1  serial data to the master, MSB first.
REQ-007 SHALL have port: miso_oe  output  1  miso drive enable; the top level tri-states miso when this is 0.
REQ-008 SHALL have port: tx_data  input  32  word returned to the master in the next frame.
REQ-009 SHALL have port: tx_load  input  1  strobe that latches tx_data.
REQ-010 SHALL have port: tx_ready  output  1  tx_load is accepted in this cycle.
REQ-011 SHALL have port: rx_data  output  32  last complete word received.
REQ-012 SHALL have port: rx_valid  output  1  rx_data is new and not yet acknowledged.
REQ-013 SHALL have port: rx_ack  input  1  consumer acknowledge that clears rx_valid.
REQ-014 SHALL have port: rx_err  output  1  one-cycle pulse when a frame is aborted.
REQ-015 SHALL have port: rx_ovr  output  1  sticky overrun flag.

Function
REQ-016 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers plus one history flop each; an edge is detected from the history flop versus the synchronized value.
REQ-017 SHALL support SPI mode 0 only (CPOL=0, CPHA=0), 32-bit frames, with fsclk <= fclk/4.
REQ-018 SHALL implement the states IDLE, SHIFT and HOLD, with the following transitions.
REQ-019 IDLE->SHIFT on a detected cs_n falling edge; in that cycle the block loads tx_shift from tx_buf, clears bit_cnt to 0, and drives miso=tx_buf[31].
REQ-020 In SHIFT, each detected sclk rising edge SHALL shift the synchronized mosi into rx_shift LSB and increment bit_cnt (6 bits).
REQ-021 In SHIFT, each detected sclk falling edge SHALL shift tx_shift left by 1; miso always equals tx_shift[31].
REQ-022 On the 32nd rising edge, the block SHALL write rx_data <= the complete word, set rx_valid=1 in the next cycle, and transition SHIFT->HOLD.
REQ-023 HOLD SHALL ignore sclk edges and keep miso at its last value; HOLD->IDLE on a detected cs_n rising edge.
REQ-024 SHIFT->IDLE on a cs_n rising edge with bit_cnt<32: rx_data is unchanged, rx_err pulses for 1 cycle, and rx_valid is unaffected.
REQ-025 miso_oe SHALL be 1 only in SHIFT and HOLD.
REQ-026 tx_ready SHALL be 1 only in IDLE; tx_load with tx_ready=1 latches tx_buf <= tx_data; tx_load with tx_ready=0 is ignored.
REQ-027 tx_buf SHALL persist across frames; an unreloaded frame resends the previous word.
REQ-028 rx_ack SHALL clear rx_valid in the next cycle.
REQ-029 When rx_ack and a frame completion coincide, rx_valid SHALL stay 1 with the new data and no overrun SHALL be flagged.
REQ-030 A cs_n falling edge detected in SHIFT or HOLD is impossible and SHALL be ignored.

Reset
REQ-031 With rst=1 at a clk edge, the block SHALL enter IDLE and set tx_buf, tx_shift, rx_shift and rx_data to 0 and bit_cnt to 0.
REQ-032 The same reset SHALL set rx_valid, rx_err, rx_ovr and miso_oe to 0, miso to 0, and tx_ready to 1; synchronizer flops reset to cs_n=1, sclk=0, mosi=0.
REQ-033 Reset mid-frame SHALL abandon the frame silently, without an rx_err pulse; the next frame is recognized only after a fresh cs_n falling edge.

Configuration
REQ-034 Macro SPI_S_OVR_EN: when defined, rx_ovr SHALL set on a frame completion while rx_valid=1 and rx_ack=0; rx_data is still overwritten, and rx_ovr clears only on rst.
REQ-035 When SPI_S_OVR_EN is undefined, rx_ovr SHALL be tied to 0 and there SHALL be no overrun logic.

Verification
REQ-036 tx_load with tx_data=32'hA5A5_0F0F in IDLE; master sends 32'h1234_5678 -> master reads A5A50F0F, rx_data=12345678, rx_valid=1 until rx_ack.
REQ-037 Frame aborted after 12 bits -> rx_err pulses once, rx_data unchanged, state IDLE, tx_ready=1.
REQ-038 Two frames without rx_ack (SPI_S_OVR_EN defined) -> rx_ovr=1, rx_data=second word; with the macro undefined -> rx_ovr=0.
REQ-039 tx_load during SHIFT with 32'hFFFF_FFFF -> ignored, current frame unaffected, the next frame resends the prior word.
REQ-040 rst asserted at bit 20 -> outputs at reset values, miso_oe=0; the following full frame with 32'hDEAD_BEEF is received correctly.
REQ-041 36 sclk pulses in a single cs_n window -> rx_data holds the first 32 bits, and the extra pulses are ignored in HOLD.

Source files
------------

// File: rtl/spi_s.sv
// SPI mode-0 slave, 32-bit frames, oversampled on clk.
// Optional overrun flag enabled by the SPI_S_OVR_EN macro.
module spi_s (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [31:0] tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        rx_err,
  output logic        rx_ovr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_q, cs_q, mosi_q;
  logic [31:0] tx_buf_q, tx_shift_q;
  logic [31:0] rx_shift_q, rx_data_q;
  logic [5:0]  bit_cnt_q;
  logic        rx_valid_q, rx_err_q;
  logic        sclk_rise, sclk_fall;
  logic        cs_rise, cs_fall;
  logic        mosi_s, done;

  // [0],[1] synchronizer stages, [2] history
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[1:0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  // data taken from the history stage, aligned with the edge history
  assign mosi_s    = mosi_q[2];

  assign done = (state_q == SHIFT) & ~cs_rise & sclk_rise
              & (bit_cnt_q == 6'd31);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_rise)   state_d = IDLE;
        else if (done) state_d = HOLD;
      end
      HOLD:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miso_oe  = 1'b0;
    tx_ready = 1'b0;
    miso     = tx_shift_q[31];
    unique case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        miso     = cs_fall & tx_buf_q[31];
      end
      SHIFT, HOLD: miso_oe = 1'b1;
      default: miso_oe = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_err_q <= 1'b0;
      if (tx_load && state_q == IDLE)
        tx_buf_q <= tx_data;
      if (state_q == IDLE && cs_fall) begin
        tx_shift_q <= tx_buf_q;
        bit_cnt_q  <= '0;
      end
      if (state_q == SHIFT) begin
        if (cs_rise) begin
          rx_err_q <= 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[30:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 6'd1;
          end
          if (done)
            rx_data_q <= {rx_shift_q[30:0], mosi_s};
          if (sclk_fall)
            tx_shift_q <= {tx_shift_q[30:0], 1'b0};
        end
      end
      if (done)        rx_valid_q <= 1'b1;
      else if (rx_ack) rx_valid_q <= 1'b0;
    end
  end

`ifdef SPI_S_OVR_EN
  logic rx_ovr_q;

  always_ff @(posedge clk) begin
    if (rst)
      rx_ovr_q <= 1'b0;
    else if (done && rx_valid_q && !rx_ack)
      rx_ovr_q <= 1'b1;
  end

  assign rx_ovr = rx_ovr_q;
`else
  assign rx_ovr = 1'b0;
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_spi_s.sv
// Directed bench for spi_s: bit-level SPI master plus a
// transaction-level model checked every idle cycle.
module tb_spi_s;

  logic        clk, rst, sclk, cs_n, mosi;
  logic        miso, miso_oe;
  logic [31:0] tx_data;
  logic        tx_load, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ack, rx_err, rx_ovr;

  spi_s dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_err   (rx_err),
    .rx_ovr   (rx_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_cycles = 0;

  logic [31:0] m_tx, m_rx;
  logic        m_valid, m_ovr;
  int          m_err;
  bit          chk_en;
  logic [31:0] rd_word;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    if (rx_err === 1'b1) err_cycles++;
    if (chk_en) begin
      chk("idle_rx_data", rx_data, m_rx);
      chk("idle_rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      chk("idle_rx_ovr", {31'd0, rx_ovr}, {31'd0, m_ovr});
      chk("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("idle_miso_oe", {31'd0, miso_oe}, 32'd0);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    m_tx = d;
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack  = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // nbits sclk pulses; load_at pulses tx_load mid-frame;
  // ack_end lines rx_ack up with the 32nd detected edge
  task automatic frame(input logic [31:0] w, input int nbits,
                       input int load_at, input bit ack_end);
    chk_en = 1'b0;
    rd_word = '0;
    @(negedge clk);
    cs_n = 1'b0;
    wait_n(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? w[31-i] : 1'b1;
      if (i == load_at) begin
        tx_data = 32'hFFFF_FFFF;
        tx_load = 1'b1;
        wait_n(1);
        tx_load = 1'b0;
        wait_n(7);
      end else begin
        wait_n(8);
      end
      if (i < 32) rd_word = {rd_word[30:0], miso};
      if (i == 0) begin
        chk("frm_miso_oe", {31'd0, miso_oe}, 32'd1);
        chk("frm_tx_ready", {31'd0, tx_ready}, 32'd0);
      end
      sclk = 1'b1;
      if (ack_end && i == 31) begin
        wait_n(2);
        rx_ack = 1'b1;
        wait_n(1);
        rx_ack = 1'b0;
        wait_n(5);
      end else begin
        wait_n(8);
      end
      sclk = 1'b0;
    end
    wait_n(8);
    cs_n = 1'b1;
    if (nbits >= 32) begin
      chk("frm_miso_word", rd_word, m_tx);
`ifdef SPI_S_OVR_EN
      if (m_valid && !ack_end) m_ovr = 1'b1;
`endif
      m_rx    = w;
      m_valid = 1'b1;
    end else begin
      m_err++;
    end
    wait_n(8);
    chk("frm_err_cycles", err_cycles, m_err);
    chk_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0;
    m_tx = '0; m_rx = '0; m_valid = 1'b0; m_ovr = 1'b0;
    m_err = 0; chk_en = 1'b0;
    wait_n(4);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_rx_ovr", {31'd0, rx_ovr}, 32'd0);
    rst = 1'b0;
    wait_n(2);
    chk_en = 1'b1;

    // basic exchange
    load(32'hA5A5_0F0F);
    frame(32'h1234_5678, 32, -1, 1'b0);
    chk("ex_miso_lit", rd_word, 32'hA5A5_0F0F);
    chk("ex_rx_lit", rx_data, 32'h1234_5678);
    wait_n(10);
    chk("ex_valid_held", {31'd0, rx_valid}, 32'd1);
    ack();
    wait_n(4);
    chk("ex_valid_clr", {31'd0, rx_valid}, 32'd0);

    // abort after 12 bits
    frame(32'hCAFE_BABE, 12, -1, 1'b0);
    chk("ab_err_lit", err_cycles, 32'd1);
    chk("ab_rx_lit", rx_data, 32'h1234_5678);
    chk("ab_ready_lit", {31'd0, tx_ready}, 32'd1);

    // ack coinciding with completion
    frame(32'h0F0F_0F0F, 32, -1, 1'b0);
    frame(32'h1357_9BDF, 32, -1, 1'b1);
    chk("co_rx_lit", rx_data, 32'h1357_9BDF);
    chk("co_valid_lit", {31'd0, rx_valid}, 32'd1);
    chk("co_ovr_lit", {31'd0, rx_ovr}, 32'd0);
    ack();

    // tx_load during SHIFT ignored; overrun on second word
    load(32'h1122_3344);
    frame(32'h0BAD_F00D, 32, 10, 1'b0);
    chk("ld_miso_lit", rd_word, 32'h1122_3344);
    frame(32'h89AB_CDEF, 32, -1, 1'b0);
    chk("ld_resend_lit", rd_word, 32'h1122_3344);
    chk("ov_rx_lit", rx_data, 32'h89AB_CDEF);
`ifdef SPI_S_OVR_EN
    chk("ov_flag_lit", {31'd0, rx_ovr}, 32'd1);
`else
    chk("ov_flag_lit", {31'd0, rx_ovr}, 32'd0);
`endif
    ack();

    // 36 pulses in one window
    frame(32'h7654_3210, 36, -1, 1'b0);
    chk("x36_rx_lit", rx_data, 32'h7654_3210);
    ack();

    // reset at bit 20
    chk_en = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    wait_n(8);
    for (int i = 0; i < 20; i++) begin
      mosi = i[0];
      wait_n(8);
      sclk = 1'b1;
      wait_n(8);
      sclk = 1'b0;
    end
    rst = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_n(4);
    m_tx = '0; m_rx = '0; m_valid = 1'b0; m_ovr = 1'b0;
    chk("mr_rx_data", rx_data, 32'd0);
    chk("mr_valid", {31'd0, rx_valid}, 32'd0);
    chk("mr_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("mr_miso", {31'd0, miso}, 32'd0);
    chk("mr_ready", {31'd0, tx_ready}, 32'd1);
    chk("mr_ovr", {31'd0, rx_ovr}, 32'd0);
    rst = 1'b0;
    wait_n(4);
    chk_en = 1'b1;
    frame(32'hDEAD_BEEF, 32, -1, 1'b0);
    chk("mr_rx_lit", rx_data, 32'hDEAD_BEEF);
    chk("mr_miso_lit", rd_word, 32'd0);
    chk("mr_err_lit", err_cycles, 32'd1);
    wait_n(4);

    chk_en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
